// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared constants and FSM encoding for the QED issue scheduler
package qed_pkg;

  localparam logic [31:0] QED_NOP     = 32'h00000013;
  localparam int          QED_COUNT_W = 8;

  typedef enum logic [1:0] {
    QED_PASS  = 2'd0,
    QED_RUN   = 2'd1,
    QED_DRAIN = 2'd2,
    QED_DONE  = 2'd3
  } qed_state_e;

endpackage

// File: rtl/qed_orig_fifo.sv
// rtl/qed_orig_fifo.sv - DEPTH x 32 originals buffer, extra-bit pointers, no bypass
module qed_orig_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty,
  output logic        last
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_rd_ptr_inc;

  assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;
  assign empty        = (r_wr_ptr == r_rd_ptr);
  assign full         = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // One entry left: the pop in progress empties the buffer.
  assign last         = (w_rd_ptr_inc == r_wr_ptr);
  assign rdata        = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

endmodule

// File: rtl/qed_issue_ctrl.sv
// rtl/qed_issue_ctrl.sv - QED issue scheduler: originals, buffered duplicates, check point
// Optional: QED_FORCE_DUP_ON_FULL_EN forces a duplicate whenever the buffer is full in QED.
module qed_issue_ctrl
  import qed_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int COUNT_W = QED_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               exec_dup,
  input  logic               qed_end,
  input  logic               stall_IF,
  input  logic [31:0]        ifu_instruction,
  input  logic               ifu_valid,
  output logic               ifu_ready,
  output logic [31:0]        dup_src_instruction,
  input  logic [31:0]        qed_instruction,
  output logic [31:0]        qic_qimux_instruction,
  output logic               qic_valid,
  output logic               qic_is_dup,
  output logic [COUNT_W-1:0] num_orig,
  output logic [COUNT_W-1:0] num_dup,
  output logic               qed_ready
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  qed_state_e         r_state;
  qed_state_e         w_state_nxt;
  logic [31:0]        r_instr;
  logic               r_valid;
  logic               r_is_dup;
  logic [COUNT_W-1:0] r_num_orig;
  logic [COUNT_W-1:0] r_num_dup;
  logic               r_sat;
  logic               r_qed_ready;

  logic [31:0]        w_instr_nxt;
  logic               w_valid_nxt;
  logic               w_dup_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_last;
  logic               w_dup_req;
  logic [31:0]        w_rd_data;

  qed_orig_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (ifu_instruction),
    .rdata (w_rd_data),
    .full  (w_full),
    .empty (w_empty),
    .last  (w_last)
  );

`ifdef QED_FORCE_DUP_ON_FULL_EN
  assign w_dup_req = exec_dup || w_full;
`else
  assign w_dup_req = exec_dup;
`endif

  assign dup_src_instruction   = w_empty ? QED_NOP : w_rd_data;
  assign qic_qimux_instruction = r_instr;
  assign qic_valid             = r_valid;
  assign qic_is_dup            = r_is_dup;
  assign num_orig              = r_num_orig;
  assign num_dup               = r_num_dup;
  assign qed_ready             = r_qed_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = QED_NOP;
    w_valid_nxt = 1'b0;
    w_dup_nxt   = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    ifu_ready   = 1'b0;
    if (!stall_IF) begin
      case (r_state)
        QED_PASS: begin
          ifu_ready = 1'b1;
          if (ifu_valid) begin
            w_instr_nxt = ifu_instruction;
            w_valid_nxt = 1'b1;
          end
          if (ena) w_state_nxt = QED_RUN;
        end
        QED_RUN: begin
          if (w_dup_req && !w_empty) begin
            w_pop       = 1'b1;
            w_instr_nxt = qed_instruction;
            w_valid_nxt = 1'b1;
            w_dup_nxt   = 1'b1;
          end else if (!w_full) begin
            ifu_ready = 1'b1;
            if (ifu_valid) begin
              w_push      = 1'b1;
              w_instr_nxt = ifu_instruction;
              w_valid_nxt = 1'b1;
            end
          end
          if (qed_end)  w_state_nxt = QED_DRAIN;
          else if (!ena) w_state_nxt = QED_PASS;
        end
        QED_DRAIN: begin
          // Draining with nothing buffered would otherwise never complete.
          if (w_empty) begin
            w_state_nxt = QED_DONE;
          end else if (exec_dup) begin
            w_pop       = 1'b1;
            w_instr_nxt = qed_instruction;
            w_valid_nxt = 1'b1;
            w_dup_nxt   = 1'b1;
            if (w_last) w_state_nxt = QED_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= QED_PASS;
      r_instr     <= QED_NOP;
      r_valid     <= 1'b0;
      r_is_dup    <= 1'b0;
      r_num_orig  <= '0;
      r_num_dup   <= '0;
      r_sat       <= 1'b0;
      r_qed_ready <= 1'b0;
    end else begin
      if (!stall_IF) begin
        r_state  <= w_state_nxt;
        r_instr  <= w_instr_nxt;
        r_valid  <= w_valid_nxt;
        r_is_dup <= w_dup_nxt;
        if (w_push && (r_num_orig != '1)) r_num_orig <= r_num_orig + CNT_ONE;
        if (w_pop && (r_num_dup != '1))   r_num_dup  <= r_num_dup + CNT_ONE;
      end
      r_sat       <= r_sat || (&r_num_orig) || (&r_num_dup);
      r_qed_ready <= (r_state == QED_DONE) && (r_num_orig == r_num_dup) &&
                     w_empty && !r_sat;
    end
  end

endmodule

// File: tb/tb_qed_issue_ctrl.sv
// tb/tb_qed_issue_ctrl.sv - directed self-checking bench for qed_issue_ctrl
module tb_qed_issue_ctrl;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] MASK = 32'h00000F80;

  logic        clk = 1'b0;
  logic        rst, ena, exec_dup, qed_end, stall_IF, ifu_valid;
  logic [31:0] ifu_instruction;
  logic        ifu_ready;
  logic [31:0] dup_src_instruction, qed_instruction, qic_qimux_instruction;
  logic        qic_valid, qic_is_dup, qed_ready;
  logic [7:0]  num_orig, num_dup;

  int checks = 0;
  int errors = 0;
  int head;

  always #5 clk = ~clk;

  // Stand-in for modify_instruction: flips the rd field.
  assign qed_instruction = dup_src_instruction ^ MASK;

  qed_issue_ctrl #(.DEPTH(16), .COUNT_W(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ena                   (ena),
    .exec_dup              (exec_dup),
    .qed_end               (qed_end),
    .stall_IF              (stall_IF),
    .ifu_instruction       (ifu_instruction),
    .ifu_valid             (ifu_valid),
    .ifu_ready             (ifu_ready),
    .dup_src_instruction   (dup_src_instruction),
    .qed_instruction       (qed_instruction),
    .qic_qimux_instruction (qic_qimux_instruction),
    .qic_valid             (qic_valid),
    .qic_is_dup            (qic_is_dup),
    .num_orig              (num_orig),
    .num_dup               (num_dup),
    .qed_ready             (qed_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; exec_dup = 1'b0; qed_end = 1'b0; stall_IF = 1'b0;
    ifu_valid = 1'b0; ifu_instruction = 32'h0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_instr", qic_qimux_instruction, NOP);
    chk("rst_valid", {31'b0, qic_valid}, 32'd0);
    chk("rst_isdup", {31'b0, qic_is_dup}, 32'd0);
    chk("rst_norig", {24'b0, num_orig}, 32'd0);
    chk("rst_ndup", {24'b0, num_dup}, 32'd0);
    chk("rst_qready", {31'b0, qed_ready}, 32'd0);
    chk("rst_dupsrc", dup_src_instruction, NOP);

    // Pass-through
    ifu_valid = 1'b1; ifu_instruction = 32'h00208133;
    chk("pass_ready", {31'b0, ifu_ready}, 32'd1);
    step();
    chk("pass_instr", qic_qimux_instruction, 32'h00208133);
    chk("pass_valid", {31'b0, qic_valid}, 32'd1);
    chk("pass_isdup", {31'b0, qic_is_dup}, 32'd0);
    chk("pass_norig", {24'b0, num_orig}, 32'd0);

    // Basic QED: three originals, one duplicate, then drain the other two
    ena = 1'b1; ifu_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      ifu_valid = 1'b1; ifu_instruction = 32'h00100093 + 32'(i << 20);
      chk("qed_push_ready", {31'b0, ifu_ready}, 32'd1);
      step();
      chk("qed_push_instr", qic_qimux_instruction, 32'h00100093 + 32'(i << 20));
      chk("qed_push_norig", {24'b0, num_orig}, 32'(i + 1));
    end
    ifu_valid = 1'b0; exec_dup = 1'b1;
    chk("qed_dupsrc0", dup_src_instruction, 32'h00100093);
    step();
    chk("qed_dup0", qic_qimux_instruction, 32'h00100093 ^ MASK);
    chk("qed_dup0_isdup", {31'b0, qic_is_dup}, 32'd1);
    exec_dup = 1'b0; qed_end = 1'b1;
    step();
    chk("qed_end_valid", {31'b0, qic_valid}, 32'd0);
    qed_end = 1'b0; ifu_valid = 1'b1; ifu_instruction = 32'h12345678;
    chk("drain_ready", {31'b0, ifu_ready}, 32'd0);
    step();
    chk("drain_nop", qic_qimux_instruction, NOP);
    chk("drain_norig", {24'b0, num_orig}, 32'd3);
    ifu_valid = 1'b0; exec_dup = 1'b1;
    step();
    chk("drain_dup1", qic_qimux_instruction, 32'h00200093 ^ MASK);
    step();
    chk("drain_dup2", qic_qimux_instruction, 32'h00300093 ^ MASK);
    chk("drain_ndup", {24'b0, num_dup}, 32'd3);
    exec_dup = 1'b0;
    step();
    chk("done_qready", {31'b0, qed_ready}, 32'd1);
    chk("done_valid", {31'b0, qic_valid}, 32'd0);

    // Full buffer
    do_reset();
    ena = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      ifu_valid = 1'b1; ifu_instruction = 32'h10000000 + 32'(i);
      step();
    end
    chk("full_norig", {24'b0, num_orig}, 32'd16);
    ifu_instruction = 32'h1000FFFF;
    chk("full_ready", {31'b0, ifu_ready}, 32'd0);
    step();
`ifdef QED_FORCE_DUP_ON_FULL_EN
    chk("full_issue", qic_qimux_instruction, 32'h10000000 ^ MASK);
    chk("full_isdup", {31'b0, qic_is_dup}, 32'd1);
    head = 1;
`else
    chk("full_issue", qic_qimux_instruction, NOP);
    chk("full_valid", {31'b0, qic_valid}, 32'd0);
    head = 0;
`endif
    chk("full_norig2", {24'b0, num_orig}, 32'd16);

    // Stall mid-stream
    ifu_valid = 1'b0; exec_dup = 1'b1;
    step();
    chk("stall_pre", qic_qimux_instruction, (32'h10000000 + 32'(head)) ^ MASK);
    stall_IF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_ready", {31'b0, ifu_ready}, 32'd0);
      step();
      chk("stall_hold", qic_qimux_instruction, (32'h10000000 + 32'(head)) ^ MASK);
      chk("stall_ndup", {24'b0, num_dup}, 32'(head + 1));
      chk("stall_dupsrc", dup_src_instruction, 32'h10000000 + 32'(head + 1));
    end
    stall_IF = 1'b0;
    step();
    chk("stall_next", qic_qimux_instruction, (32'h10000000 + 32'(head + 1)) ^ MASK);
    chk("stall_ndup2", {24'b0, num_dup}, 32'(head + 2));

    // Wrap-around: 40 push/pop pairs, then fill to full at a wrapped pointer
    do_reset();
    ena = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      ifu_valid = 1'b1; exec_dup = 1'b0; ifu_instruction = 32'hA0000000 + 32'(i);
      step();
      ifu_valid = 1'b0; exec_dup = 1'b1;
      step();
      chk("wrap_dup", qic_qimux_instruction, (32'hA0000000 + 32'(i)) ^ MASK);
      chk("wrap_empty", dup_src_instruction, NOP);
    end
    exec_dup = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ifu_valid = 1'b1; ifu_instruction = 32'hB0000000 + 32'(i);
      step();
    end
    chk("wrap_full_ready", {31'b0, ifu_ready}, 32'd0);
    chk("wrap_norig", {24'b0, num_orig}, 32'd56);
    chk("wrap_head", dup_src_instruction, 32'hB0000000);

    // Reset mid-drain with 5 entries buffered
    do_reset();
    ena = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      ifu_valid = 1'b1; ifu_instruction = 32'hC0000000 + 32'(i);
      step();
    end
    ifu_valid = 1'b0; qed_end = 1'b1;
    step();
    qed_end = 1'b0;
    chk("mid_dupsrc", dup_src_instruction, 32'hC0000000);
    rst = 1'b1; exec_dup = 1'b1;
    step();
    rst = 1'b0; exec_dup = 1'b0; ena = 1'b0;
    chk("mid_instr", qic_qimux_instruction, NOP);
    chk("mid_valid", {31'b0, qic_valid}, 32'd0);
    chk("mid_norig", {24'b0, num_orig}, 32'd0);
    chk("mid_ndup", {24'b0, num_dup}, 32'd0);
    chk("mid_qready", {31'b0, qed_ready}, 32'd0);
    chk("mid_empty", dup_src_instruction, NOP);
    ifu_valid = 1'b1; ifu_instruction = 32'h00310233;
    step();
    chk("mid_pass", qic_qimux_instruction, 32'h00310233);
    chk("mid_pass_isdup", {31'b0, qic_is_dup}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qed_issue_ctrl.md
# qed_issue_ctrl

Issue scheduler for the QED instruction path; it sits between the fetch stage and the core's instruction-mux input. It buffers every original instruction it issues and later re-issues each one, in order, as its duplicate. The duplicate encoding comes from `modify_instruction`, which is fed from the buffer head. The block counts originals and duplicates, inserts NOPs when nothing may issue, and raises a check-point flag once every original has been matched by its duplicate.

## Interface
Parameters:
- `DEPTH`, 16: originals buffer depth; must be a power of two, at least 2.
- `COUNT_W`, 8: width of the original and duplicate counters.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `ena` in 1: QED mode enable; low means pass-through.
- `exec_dup` in 1: free input requesting that a duplicate be issued this cycle.
- `qed_end` in 1: stop issuing originals and drain the buffer.
- `stall_IF` in 1: pipeline stall; freezes the block.
- `ifu_instruction` in 32: original instruction from fetch.
- `ifu_valid` in 1: `ifu_instruction` is valid.
- `ifu_ready` out 1: this cycle's original is accepted (combinational).
- `dup_src_instruction` out 32: buffer head, driven to `modify_instruction`; NOP when the buffer is empty.
- `qed_instruction` in 32: transformed duplicate returned from `modify_instruction`.
- `qic_qimux_instruction` out 32: issued instruction (registered).
- `qic_valid` out 1: issued slot carries a real instruction.
- `qic_is_dup` out 1: issued slot is a duplicate.
- `num_orig` out `COUNT_W`: originals issued.
- `num_dup` out `COUNT_W`: duplicates issued.
- `qed_ready` out 1: check point reached (registered).

## Operation
FSM states are PASS, QED, DRAIN and DONE. The reset state is PASS.
- **PASS**: `ifu_instruction` is forwarded whenever `ifu_valid` is high.
  - `ifu_ready` equals `!stall_IF`.
  - The buffer and counters are untouched.
  - `ena` going high moves the FSM to QED.
- **QED**: on each non-stalled cycle, the first matching rule applies:
  - `exec_dup` high and buffer non-empty: issue `qed_instruction` and pop the buffer.
  - `ifu_valid` high and buffer not full: issue `ifu_instruction`, push it, and drive `ifu_ready` high.
  - Otherwise: issue NOP `32'h00000013` with `qic_valid` low.
  - `qed_end` moves the FSM to DRAIN. `ena` low moves it to PASS, leaving the buffer and counters held.
- **DRAIN**:
  - Duplicates are issued only when `exec_dup` is high; otherwise a NOP is issued.
  - `ifu_ready` is 0.
  - The FSM moves to DONE on the cycle the last entry pops.
- **DONE**:
  - NOPs are issued and `ifu_ready` is 0.
  - `qed_ready` is 1 while `num_orig == num_dup` and the buffer is empty.
  - Only `rst` leaves DONE.
- Buffer behaviour:
  - FIFO order is preserved.
  - Push and pop never occur in the same cycle.
  - The full and empty flags use pointers one bit wider than the address, and wrap-around is seamless.
- Counter behaviour:
  - `num_orig` increments on each push and `num_dup` on each pop.
  - Both saturate at all-ones.
  - Once either counter saturates, `qed_ready` is forced to 0 until reset.
- `rst` takes priority over every other input. It clears the pointers, the counters and the FSM (to PASS), and drives the NOP on the output, including when asserted mid-drain.

## Timing
- Issue latency is 1 cycle: the decision is made in cycle N and `qic_*` is valid in cycle N+1.
- `ifu_ready` is combinational in cycle N. Fetch must treat the instruction as consumed only when `ifu_valid && ifu_ready`.
- While `stall_IF` is high:
  - The `qic_*` registers, FSM, pointers and counters all hold.
  - `ifu_ready` is 0.
  - `qed_end` and `ena` transitions are deferred until the stall is released.
- `dup_src_instruction` is combinational from the buffer read pointer.
- `qed_instruction` has a 0-cycle combinational path back through `modify_instruction`.
- Reset values:
  - `qic_qimux_instruction` is the NOP (`32'h00000013`).
  - `qic_valid`, `qic_is_dup`, `qed_ready` and both counters are 0.

## Configuration
- `QED_FORCE_DUP_ON_FULL_EN` defined: in QED with the buffer full, a duplicate is issued regardless of `exec_dup`.
- Macro undefined: a full buffer with `exec_dup` low issues a NOP and holds `ifu_ready` at 0.

## Structure
- `qed_pkg` holds:
  - the `QED_NOP` constant;
  - the FSM state enum (`QED_PASS`, `QED_RUN`, `QED_DRAIN`, `QED_DONE`);
  - the default `COUNT_W`.
- One sub-module, `qed_orig_fifo`: parameterised `DEPTH` × 32 storage with push, pop, full and empty; no bypass.

## Test plan
- **Pass-through**: `ena`=0, `ifu_valid`=1, instruction `32'h00208133`.
  - Next cycle: `qic_qimux_instruction`=`32'h00208133`, `qic_is_dup`=0, counters 0.
- **Basic QED**: three originals pushed, then `exec_dup`=1 for three cycles.
  - Duplicates are issued in push order.
  - `num_orig`=`num_dup`=3.
  - After `qed_end` and the drain, `qed_ready`=1.
- **Full buffer**: push 16 originals with `exec_dup`=0.
  - `ifu_ready`=0 on the 17th cycle.
  - With `QED_FORCE_DUP_ON_FULL_EN` defined, a duplicate issues on that cycle.
  - Without the macro, a NOP issues.
- **Stall**: assert `stall_IF` for 4 cycles mid-stream.
  - Outputs, counters and pointers are unchanged.
  - The next issue is the instruction pending before the stall.
- **Wrap-around**: run 40 push/pop pairs through `DEPTH`=16.
  - Order is preserved throughout.
  - The empty and full flags are correct at every wrap.
- **Reset mid-drain**: assert `rst` with 5 entries buffered.
  - Next cycle: state PASS, buffer empty, counters 0, output NOP, `qed_ready`=0.
